// File: rtl/carry_resolve.sv
// carry_resolve
// -------------
// Converts one redundant polynomial word (ADD_DIV limbs, each LIMB_W+CARRY_W
// bits wide, as produced by cmul) into canonical LIMB_W-bit limbs. The carry
// ripples serially from limb 0 upward, resolving one limb per clock.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   din_valid   din holds a valid redundant word
//   din_ready   block accepts a word this cycle (IDLE only)
//   din         ADD_DIV redundant limbs, limb i at [i*(LIMB_W+CARRY_W) +: LIMB_W+CARRY_W]
//   dout_valid  dout/carry_out hold a resolved word (DONE only)
//   dout_ready  consumer takes dout this cycle
//   dout        canonical word, limb i at [i*LIMB_W +: LIMB_W]
//   carry_out   carry out of the top limb (CARRY_W+1 bits)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. din is sampled only in IDLE, and dout is held unchanged from the
// start of DONE until its transfer. The state register is the typed enum
// 'state' and is visible hierarchically for debug.
//
// Result: dout + carry_out * 2^(ADD_DIV*LIMB_W) == sum_i din[i] * 2^(i*LIMB_W)

module carry_resolve #(
  parameter int ADD_DIV = 4,
  parameter int LIMB_W  = 64,
  parameter int CARRY_W = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                din_valid,
  output logic                                din_ready,
  input  logic [ADD_DIV*(LIMB_W+CARRY_W)-1:0] din,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic [ADD_DIV*LIMB_W-1:0]           dout,
  output logic [CARRY_W:0]                    carry_out
);

  localparam int IN_W  = LIMB_W + CARRY_W;
  localparam int SUM_W = IN_W + 1;
  localparam int IDX_W = (ADD_DIV > 1) ? $clog2(ADD_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [IN_W-1:0]   limb_q [ADD_DIV];
  logic [LIMB_W-1:0] res_q  [ADD_DIV];
  logic [IDX_W-1:0]  idx;
  // Worst-case carry is 2^CARRY_W, which needs CARRY_W+1 bits.
  logic [CARRY_W:0]  carry;
  logic [SUM_W-1:0]  sum;
  logic              accept;
  logic              last;

  assign accept = (state == IDLE) && din_valid;
  assign last   = (idx == LAST_IDX);
  // Largest sum is (2^IN_W - 1) + 2^CARRY_W, which fits in IN_W+1 bits.
  assign sum    = SUM_W'(limb_q[idx]) + SUM_W'(carry);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    unique case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          state_nxt = PROP;
        end
      end
      PROP: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= '0;
      for (int i = 0; i < ADD_DIV; i++) begin
        limb_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < ADD_DIV; i++) begin
        limb_q[i] <= din[i*IN_W +: IN_W];
      end
      idx   <= '0;
      carry <= '0;
    end else if (state == PROP) begin
      res_q[idx] <= sum[LIMB_W-1:0];
      carry      <= sum[SUM_W-1:LIMB_W];
      // Wraps (or runs past the last limb) after the final limb; it is
      // cleared again when the next word is accepted.
      idx        <= idx + 1'b1;
    end
  end

  // res_q and carry are untouched in DONE, so dout/carry_out hold stable.
  for (genvar g = 0; g < ADD_DIV; g++) begin : g_dout
    assign dout[g*LIMB_W +: LIMB_W] = res_q[g];
  end

  assign carry_out = carry;

endmodule

// File: tb/tb_carry_resolve.sv
// tb_carry_resolve
// ----------------
// Directed bench for carry_resolve at ADD_DIV=4, LIMB_W=8, CARRY_W=2, followed
// by a short random run scored against an arithmetic model of the result.
// Expected values for directed words are worked out by hand.

module tb_carry_resolve;

  localparam int ADD_DIV = 4;
  localparam int LIMB_W  = 8;
  localparam int CARRY_W = 2;
  localparam int IN_W    = LIMB_W + CARRY_W;
  localparam int DIN_W   = ADD_DIV * IN_W;
  localparam int DOUT_W  = ADD_DIV * LIMB_W;
  localparam int RES_W   = DOUT_W + CARRY_W + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               din_valid;
  logic               din_ready;
  logic [DIN_W-1:0]   din;
  logic               dout_valid;
  logic               dout_ready;
  logic [DOUT_W-1:0]  dout;
  logic [CARRY_W:0]   carry_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [RES_W-1:0] exp_q[$];

  carry_resolve #(
    .ADD_DIV (ADD_DIV),
    .LIMB_W  (LIMB_W),
    .CARRY_W (CARRY_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .carry_out  (carry_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_din_ready"},  64'(din_ready),  64'd1);
    chk({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_dout"},       64'(dout),       64'd0);
    chk({tag, "_carry_out"},  64'(carry_out),  64'd0);
  endtask

  function automatic logic [RES_W-1:0] model(input logic [DIN_W-1:0] w);
    logic [RES_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADD_DIV; i++) begin
      acc = acc + (RES_W'(w[i*IN_W +: IN_W]) << (i * LIMB_W));
    end
    return acc;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge right after the
  // word was accepted (first PROP cycle).
  task automatic send_word(input logic [DIN_W-1:0] w);
    int t;
    t = 0;
    din       = w;
    din_valid = 1'b1;
    while (!din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", 64'(t < 200), 64'd1);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Waits from the first PROP cycle for dout_valid, checking latency and value.
  task automatic expect_result(input string tag, input logic [RES_W-1:0] exp);
    int cnt;
    cnt = 0;
    while (!dout_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 64'(cnt), 64'(ADD_DIV));
    chk({tag, "_result"},  64'({carry_out, dout}), 64'(exp));
  endtask

  task automatic finish_hs(input string tag);
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_dropped"}, 64'(dout_valid), 64'd0);
    chk({tag, "_back_idle"},     64'(din_ready),  64'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [DIN_W-1:0] word_a;
  logic [DIN_W-1:0] word_b;
  logic [DIN_W-1:0] word_w;
  logic [RES_W-1:0] exp_v;
  logic             bad;
  logic             got;
  int               t;

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din        = '0;
    dout_ready = 1'b1;

    // Reset values before any clock edge, then across clock edges.
    #1;
    check_reset_outputs("rst_t0");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_clocked");

    // No-carry word presented while still in reset: must not be taken.
    din       = {10'h000, 10'h000, 10'h001, 10'h023};
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ignores_valid", 64'(din_ready), 64'd1);

    // First rising edge after reset release accepts the word.
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("accept_first_edge", 64'(din_ready), 64'd0);
    din_valid = 1'b0;
    expect_result("no_carry", {3'd0, 32'h0000_0123});
    finish_hs("no_carry");

    // Full ripple: 0x100 in limb 0 carries through three 0xFF limbs.
    send_word({10'h0FF, 10'h0FF, 10'h0FF, 10'h100});
    expect_result("ripple", {3'd1, 32'h0000_0000});
    finish_hs("ripple");

    // Worst case: every limb 0x3FF, final carry 4.
    send_word({10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF});
    expect_result("worst", {3'd4, 32'h0303_02FF});
    finish_hs("worst");

    // Backpressure: word A held in DONE while word B waits on din.
    word_a = {10'h010, 10'h200, 10'h001, 10'h0FF};
    word_b = {10'h004, 10'h003, 10'h002, 10'h001};
    dout_ready = 1'b0;
    send_word(word_a);
    expect_result("bp_a", {3'd0, 32'h1200_01FF});
    din       = word_b;
    din_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_dout",   64'({carry_out, dout}), 64'({3'd0, 32'h1200_01FF}));
      chk("bp_hold_valid",  64'(dout_valid), 64'd1);
      chk("bp_hold_nready", 64'(din_ready),  64'd0);
    end
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_idle",  64'(din_ready),  64'd1);
    chk("bp_release_valid", 64'(dout_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_b_accepted", 64'(din_ready), 64'd0);
    din_valid = 1'b0;
    expect_result("bp_b", {3'd0, 32'h0403_0201});
    finish_hs("bp_b");

    // Reset pulsed during the second PROP cycle.
    send_word({10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF});
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_prop");
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dout_valid) bad = 1'b1;
    end
    chk("rst_no_valid_pulse", 64'(bad), 64'd0);
    send_word({10'h3FF, 10'h000, 10'h000, 10'h3FF});
    expect_result("after_rst", {3'd3, 32'hFF00_03FF});
    finish_hs("after_rst");

    // Random words with random input gaps and random output backpressure.
    for (int n = 0; n < 200; n++) begin
      din_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        din = DIN_W'({$urandom, $urandom});
        @(negedge clk);
      end
      word_w = DIN_W'({$urandom, $urandom});
      exp_q.push_back(model(word_w));
      send_word(word_w);
      got = 1'b0;
      t   = 0;
      while (!got && t < 100) begin
        dout_ready = 1'($urandom_range(0, 1));
        if (dout_valid && dout_ready) begin
          exp_v = exp_q.pop_front();
          chk("rand_word", 64'({carry_out, dout}), 64'(exp_v));
          got = 1'b1;
        end
        @(negedge clk);
        t++;
      end
      chk("rand_timeout", 64'(got), 64'd1);
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
